// File: rtl/dvp_pkg.sv
// Shared types and default timing for the DVP byte transmitter (480x272 panel).
// Holds the frame FSM state encoding and the line-length helper.
package dvp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    VBACK,
    ACTIVE,
    VFRONT
  } dvp_state_e;

  localparam int DEF_H_ACTIVE    = 480;
  localparam int DEF_V_ACTIVE    = 272;
  localparam int DEF_H_BLANK     = 32;
  localparam int DEF_VSYNC_LINES = 2;
  localparam int DEF_V_BACK      = 4;
  localparam int DEF_V_FRONT     = 2;

  // Byte clocks per line: two bytes per active pixel plus horizontal blank.
  function automatic int h_total(input int h_active, input int h_blank);
    return 2 * h_active + h_blank;
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/dvp_timing_gen.sv
// Frame FSM with horizontal byte counter and per-state line counter.
// Combinational outputs reflect the current counter state; enable is sampled at frame boundaries only.
module dvp_timing_gen
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int H_BLANK     = DEF_H_BLANK,
  parameter int VSYNC_LINES = DEF_VSYNC_LINES,
  parameter int V_BACK      = DEF_V_BACK,
  parameter int V_FRONT     = DEF_V_FRONT
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       enable,
  output dvp_state_e state,
  output logic       active_byte,
  output logic       even_byte,
  output logic       sof_cyc
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_BLANK);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int L_MAX   = max4(VSYNC_LINES, V_BACK, V_ACTIVE, V_FRONT);
  localparam int LW      = (L_MAX > 1) ? $clog2(L_MAX) : 1;

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_B = HW'(2 * H_ACTIVE);
  localparam logic [LW-1:0] VS_LAST = LW'((VSYNC_LINES > 0) ? VSYNC_LINES - 1 : 0);
  localparam logic [LW-1:0] VB_LAST = LW'((V_BACK > 0) ? V_BACK - 1 : 0);
  localparam logic [LW-1:0] VA_LAST = LW'((V_ACTIVE > 0) ? V_ACTIVE - 1 : 0);
  localparam logic [LW-1:0] VF_LAST = LW'((V_FRONT > 0) ? V_FRONT - 1 : 0);

  dvp_state_e    state_q, state_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [LW-1:0] line_q, line_d;
  logic          h_wrap;
  logic [LW-1:0] line_last;
  dvp_state_e    exit_state;

  always_comb begin
    state_d    = state_q;
    h_cnt_d    = h_cnt_q;
    line_d     = line_q;
    h_wrap     = (h_cnt_q == H_LAST);
    line_last  = '0;
    exit_state = IDLE;

    case (state_q)
      VSYNC: begin
        line_last  = VS_LAST;
        exit_state = (V_BACK > 0) ? VBACK : ACTIVE;
      end
      VBACK: begin
        line_last  = VB_LAST;
        exit_state = ACTIVE;
      end
      ACTIVE: begin
        line_last = VA_LAST;
        if (V_FRONT > 0) exit_state = VFRONT;
        else             exit_state = enable ? VSYNC : IDLE;
      end
      VFRONT: begin
        line_last  = VF_LAST;
        exit_state = enable ? VSYNC : IDLE;
      end
      default: begin
        line_last  = '0;
        exit_state = IDLE;
      end
    endcase

    if (state_q == IDLE) begin
      h_cnt_d = '0;
      line_d  = '0;
      if (enable) state_d = VSYNC;
    end else begin
      h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
      if (h_wrap) begin
        if (line_q == line_last) begin
          line_d  = '0;
          state_d = exit_state;
        end else begin
          line_d = line_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q <= IDLE;
      h_cnt_q <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      h_cnt_q <= h_cnt_d;
      line_q  <= line_d;
    end
  end

  assign state       = state_q;
  assign active_byte = (state_q == ACTIVE) && (h_cnt_q < H_ACT_B);
  assign even_byte   = ~h_cnt_q[0];
  assign sof_cyc     = (state_q == VSYNC) && (h_cnt_q == '0) && (line_q == '0);

endmodule

// File: rtl/dvp_16_8bit_tx.sv
// RGB565 pixel stream to DVP byte stream (hi byte first); outputs registered one cycle after timing.
// Single-pixel holding buffer: px_ready drops only while full and not being drained this cycle.
module dvp_16_8bit_tx
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int H_BLANK     = DEF_H_BLANK,
  parameter int VSYNC_LINES = DEF_VSYNC_LINES,
  parameter int V_BACK      = DEF_V_BACK,
  parameter int V_FRONT     = DEF_V_FRONT
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] px_data,
  input  logic        px_valid,
  output logic        px_ready,
  output logic [7:0]  dvp_data,
  output logic        dvp_href,
  output logic        dvp_vsync,
  output logic        sof,
  output logic        underrun
);

  dvp_state_e state;
  logic       active_byte;
  logic       even_byte;
  logic       sof_cyc;

  dvp_timing_gen #(
    .H_ACTIVE   (H_ACTIVE),
    .V_ACTIVE   (V_ACTIVE),
    .H_BLANK    (H_BLANK),
    .VSYNC_LINES(VSYNC_LINES),
    .V_BACK     (V_BACK),
    .V_FRONT    (V_FRONT)
  ) u_timing (
    .pclk       (pclk),
    .rst        (rst),
    .enable     (enable),
    .state      (state),
    .active_byte(active_byte),
    .even_byte  (even_byte),
    .sof_cyc    (sof_cyc)
  );

  logic [15:0] buf_q, buf_d;
  logic        full_q, full_d;
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  data_q, data_d;
  logic        href_q, href_d;
  logic        vsync_q, vsync_d;
  logic        sof_q, sof_d;
  logic        underrun_q, underrun_d;
  logic        slot;
  logic        take;
  logic        accept;

  always_comb begin
    slot       = active_byte && even_byte;
    take       = slot && full_q;
    px_ready   = !rst && (!full_q || take);
    accept     = px_valid && px_ready;

    full_d     = accept | (full_q & ~take);
    buf_d      = accept ? px_data : buf_q;
    lo_d       = lo_q;
    data_d     = 8'h00;
    underrun_d = underrun_q;

    // An empty slot still consumes its two byte times and emits zeros.
    if (slot) begin
      if (full_q) begin
        data_d = buf_q[15:8];
        lo_d   = buf_q[7:0];
      end else begin
        lo_d       = 8'h00;
        underrun_d = 1'b1;
      end
    end else if (active_byte) begin
      data_d = lo_q;
    end

    href_d  = active_byte;
    vsync_d = (state == VSYNC);
    sof_d   = sof_cyc;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      buf_q      <= '0;
      full_q     <= 1'b0;
      lo_q       <= '0;
      data_q     <= '0;
      href_q     <= 1'b0;
      vsync_q    <= 1'b0;
      sof_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      full_q     <= full_d;
      lo_q       <= lo_d;
      data_q     <= data_d;
      href_q     <= href_d;
      vsync_q    <= vsync_d;
      sof_q      <= sof_d;
      underrun_q <= underrun_d;
    end
  end

  assign dvp_data  = data_q;
  assign dvp_href  = href_q;
  assign dvp_vsync = vsync_q;
  assign sof       = sof_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_dvp_16_8bit_tx.sv
// Directed bench for dvp_16_8bit_tx on a tiny 4x2 frame (10 byte clocks per line, 5 lines per frame).
module tb_dvp_16_8bit_tx;

  logic        pclk;
  logic        rst;
  logic        enable;
  logic [15:0] px_data;
  logic        px_valid;
  logic        px_ready;
  logic [7:0]  dvp_data;
  logic        dvp_href;
  logic        dvp_vsync;
  logic        sof;
  logic        underrun;

  int checks   = 0;
  int failures = 0;
  int sof_cnt, vs_cnt, acc_cnt, pix_idx, run_len;
  logic href_prev, rdy_s, tog;
  logic [7:0]  got[$];
  logic [15:0] accq[$];

  dvp_16_8bit_tx #(
    .H_ACTIVE(4), .V_ACTIVE(2), .H_BLANK(2),
    .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)
  ) dut (
    .pclk     (pclk),
    .rst      (rst),
    .enable   (enable),
    .px_data  (px_data),
    .px_valid (px_valid),
    .px_ready (px_ready),
    .dvp_data (dvp_data),
    .dvp_href (dvp_href),
    .dvp_vsync(dvp_vsync),
    .sof      (sof),
    .underrun (underrun)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic logic [15:0] pix(input int k);
    return 16'h1234 + 16'(k) * 16'h4444;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    sof_cnt = 0;
    vs_cnt  = 0;
    acc_cnt = 0;
    got.delete();
    accq.delete();
  endtask

  // One clock: sample handshake at negedge, outputs #1 after posedge, then update the source.
  task automatic tick();
    logic acc;
    @(negedge pclk);
    acc   = px_valid && px_ready;
    rdy_s = px_ready;
    @(posedge pclk);
    #1;
    if (sof) sof_cnt++;
    if (dvp_vsync) vs_cnt++;
    if (dvp_href) begin
      got.push_back(dvp_data);
      run_len++;
    end else begin
      if (!rst && href_prev) chk("href_run_len", run_len, 8);
      run_len = 0;
    end
    href_prev = dvp_href;
    if (acc) begin
      accq.push_back(px_data);
      acc_cnt++;
      pix_idx++;
      px_data = pix(pix_idx);
    end
    if (tog) px_valid = !px_valid;
  endtask

  initial begin
    logic [15:0] p;
    logic [7:0]  eb;
    rst = 1'b1; enable = 1'b0; px_valid = 1'b0; tog = 1'b0;
    pix_idx = 0; px_data = pix(0); run_len = 0; href_prev = 1'b0; rdy_s = 1'b0;
    clear_counts();

    // Reset and IDLE
    repeat (3) tick();
    chk("rst_data", dvp_data, 0);
    chk("rst_href", dvp_href, 0);
    chk("rst_vsync", dvp_vsync, 0);
    chk("rst_sof", sof, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_ready", rdy_s, 0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", px_ready, 1);
    px_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      tick();
      chk("idle_outputs", {dvp_vsync, dvp_href, sof, underrun, dvp_data}, 0);
    end
    chk("idle_accepts", acc_cnt, 1);
    chk("idle_ready_full", px_ready, 0);

    // Full frame, continuous pixels
    clear_counts();
    enable = 1'b1;
    tick();
    chk("f1_sof_early", sof, 0);
    tick();
    chk("f1_sof", sof, 1);
    chk("f1_vsync", dvp_vsync, 1);
    repeat (49) tick();
    chk("f1_sof_cnt", sof_cnt, 1);
    chk("f1_vsync_cnt", vs_cnt, 10);
    chk("f1_accepts", acc_cnt, 8);
    chk("f1_underrun", underrun, 0);
    chk("f1_nbytes", got.size(), 16);
    chk("f1_b0", got[0], 8'h12);
    chk("f1_b1", got[1], 8'h34);
    chk("f1_b2", got[2], 8'h56);
    chk("f1_b3", got[3], 8'h78);
    for (int i = 0; i < 16; i++) begin
      p  = pix(i / 2);
      eb = (i % 2 == 0) ? p[15:8] : p[7:0];
      chk("f1_byte", got[i], eb);
    end

    // Second frame; enable drops mid-ACTIVE, frame completes then IDLE
    clear_counts();
    for (int t = 52; t <= 140; t++) begin
      tick();
      if (t == 75) enable = 1'b0;
    end
    chk("f2_sof_cnt", sof_cnt, 1);
    chk("f2_vsync_cnt", vs_cnt, 10);
    chk("f2_accepts", acc_cnt, 8);
    chk("f2_nbytes", got.size(), 16);
    for (int i = 0; i < 16; i++) begin
      p  = pix(8 + i / 2);
      eb = (i % 2 == 0) ? p[15:8] : p[7:0];
      chk("f2_byte", got[i], eb);
    end
    chk("f2_idle_vsync", dvp_vsync, 0);
    enable = 1'b1;
    tick();
    chk("reen_sof_early", sof, 0);
    tick();
    chk("reen_sof", sof, 1);

    // Throttled source: px_valid toggles every cycle
    rst = 1'b1; enable = 1'b0; px_valid = 1'b0;
    tick();
    tick();
    chk("bp_rst_ready", rdy_s, 0);
    chk("bp_rst_href", dvp_href, 0);
    clear_counts();
    rst = 1'b0; enable = 1'b1; px_valid = 1'b1; tog = 1'b1;
    for (int t = 1; t <= 60; t++) begin
      tick();
      if (t == 5) enable = 1'b0;
      if ((t >= 2 && t <= 21) || t == 30 || t == 31) chk("bp_ready_full", rdy_s, 0);
    end
    tog = 1'b0; px_valid = 1'b0;
    chk("bp_underrun", underrun, 0);
    chk("bp_sof_cnt", sof_cnt, 1);
    chk("bp_nbytes", got.size(), 16);
    for (int i = 0; i < 16; i++) begin
      p  = accq[i / 2];
      eb = (i % 2 == 0) ? p[15:8] : p[7:0];
      chk("bp_byte", got[i], eb);
    end

    // Underrun on line 1, pixels supplied for line 2
    rst = 1'b1;
    tick();
    tick();
    clear_counts();
    rst = 1'b0; enable = 1'b1; px_valid = 1'b0;
    for (int t = 1; t <= 60; t++) begin
      tick();
      if (t == 5) enable = 1'b0;
      if (t == 29) px_valid = 1'b1;
      if (t == 21) chk("ur_before", underrun, 0);
      if (t == 22) chk("ur_set", underrun, 1);
    end
    chk("ur_sticky", underrun, 1);
    chk("ur_nbytes", got.size(), 16);
    for (int i = 0; i < 8; i++) chk("ur_line1_zero", got[i], 0);
    for (int i = 0; i < 8; i++) begin
      p  = accq[i / 2];
      eb = (i % 2 == 0) ? p[15:8] : p[7:0];
      chk("ur_line2_byte", got[8 + i], eb);
    end

    // Reset during href with enable held high
    enable = 1'b1;
    for (int i = 0; i < 80 && !dvp_href; i++) tick();
    chk("mr_href_seen", dvp_href, 1);
    rst = 1'b1;
    tick();
    chk("mr_href", dvp_href, 0);
    chk("mr_data", dvp_data, 0);
    chk("mr_underrun", underrun, 0);
    chk("mr_vsync", dvp_vsync, 0);
    rst = 1'b0;
    tick();
    chk("mr_sof_early", sof, 0);
    tick();
    chk("mr_sof", sof, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
